rb_apb4_bridge: RTL



---
 rtl/rb_apb_pkg.sv | 30 +++
 rtl/rb_tmo_cnt.sv | 31 +++
 rtl/rb_apb4_bridge.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/rb_apb_pkg.sv
// Shared state type and sizing helpers for the APB4-to-register-bus bridge.
// Sizes that depend on DATA_W come from the helper functions.
package rb_apb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rb_br_state_e;

    // Helper values for the default 32-bit data path.
    localparam int RB_DATA_W = 32;
    localparam int STRB_W    = RB_DATA_W / 8;
    localparam int ALIGN_LSB = $clog2(STRB_W);

    function automatic int rb_strb_w(input int data_w);
        return data_w / 8;
    endfunction

    function automatic int rb_align_lsb(input int data_w);
        return $clog2(data_w / 8);
    endfunction

    // A zero timeout still needs a one-bit counter so the port map stays uniform.
    function automatic int rb_tmo_cnt_w(input int timeout);
        return (timeout < 1) ? 1 : $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/rb_tmo_cnt.sv
// Strobe-to-ack timeout down-counter: load on transfer start, count while waiting,
// expire in the last allowed cycle. TIMEOUT=0 never expires.
module rb_tmo_cnt
    import rb_apb_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = rb_tmo_cnt_w(TIMEOUT)
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_load,
    input  logic i_en,
    output logic o_expire
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= CNT_W'(TIMEOUT);
        end else if (i_en && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    // Count value 1 marks the TIMEOUT-th waiting cycle.
    assign o_expire = (TIMEOUT != 0) && i_en && (r_cnt == CNT_W'(1));

endmodule

// File: rtl/rb_apb4_bridge.sv
// Registered APB4 slave that turns one APB transfer into a single-cycle register-bus
// strobe, waits for the ack with a bounded timeout and returns PREADY/PRDATA/PSLVERR.
module rb_apb4_bridge
    import rb_apb_pkg::*;
#(
    parameter int ADDR_W      = 12,
    parameter int DATA_W      = 32,
    parameter int TIMEOUT     = 16,
    parameter int CHECK_PROT  = 0,
    parameter int CHECK_ALIGN = 1
) (
    input  logic                  apb_pclk,
    input  logic                  apb_preset,
    input  logic [ADDR_W-1:0]     apb_paddr,
    input  logic                  apb_psel,
    input  logic                  apb_penable,
    input  logic                  apb_pwrite,
    input  logic [DATA_W-1:0]     apb_pwdata,
    input  logic [DATA_W/8-1:0]   apb_pstrb,
    input  logic [2:0]            apb_pprot,
    output logic                  apb_pready,
    output logic [DATA_W-1:0]     apb_prdata,
    output logic                  apb_pslverr,
    output logic                  rd_en,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     raddr,
    output logic [ADDR_W-1:0]     waddr,
    output logic [DATA_W-1:0]     wdata,
    output logic [DATA_W/8-1:0]   wstrb,
    input  logic [DATA_W-1:0]     rdata,
    input  logic                  rack,
    input  logic                  wack,
    input  logic                  raddrerr,
    input  logic                  waddrerr,
    output logic                  bus_tmo
);

    localparam int                SW         = rb_strb_w(DATA_W);
    localparam int                AL         = rb_align_lsb(DATA_W);
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'((1 << AL) - 1);

    rb_br_state_e      r_state, w_state_nxt;
    logic              r_write;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata, r_prdata, w_prdata_nxt;
    logic [SW-1:0]     r_wstrb;
    logic              r_pslverr, w_err_nxt;
    logic              r_bus_tmo, w_tmo_nxt;
    logic              w_start, w_chk_fail, w_ack, w_addrerr;
    logic              w_cnt_load, w_cnt_en, w_expire;
    logic              w_unused_prot;

    assign w_unused_prot = ^{apb_pprot[2], apb_pprot[0]};

    // Rejections are decided on the live access-phase inputs, before any strobe.
    assign w_chk_fail = ((CHECK_PROT != 0) && apb_pprot[1])
                     || ((CHECK_ALIGN != 0) && ((apb_paddr & ALIGN_MASK) != '0))
                     || (!apb_pwrite && (apb_pstrb != '0));

    assign w_ack     = r_write ? wack     : rack;
    assign w_addrerr = r_write ? waddrerr : raddrerr;

    rb_tmo_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_tmo_cnt (
        .i_clk    (apb_pclk),
        .i_reset  (apb_preset),
        .i_load   (w_cnt_load),
        .i_en     (w_cnt_en),
        .o_expire (w_expire)
    );

    always_ff @(posedge apb_pclk) begin
        if (apb_preset) begin
            r_state   <= IDLE;
            r_write   <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_prdata  <= '0;
            r_pslverr <= 1'b0;
            r_bus_tmo <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_prdata  <= w_prdata_nxt;
            r_pslverr <= w_err_nxt;
            r_bus_tmo <= w_tmo_nxt;
            if (w_start) begin
                r_write <= apb_pwrite;
                r_addr  <= apb_paddr;
                r_wdata <= apb_pwdata;
                r_wstrb <= apb_pstrb;
            end
        end
    end

    // Response fields are only non-zero on the transition into RESP.
    always_comb begin
        w_state_nxt  = r_state;
        w_prdata_nxt = '0;
        w_err_nxt    = 1'b0;
        w_tmo_nxt    = 1'b0;
        w_start      = 1'b0;
        w_cnt_load   = 1'b0;
        w_cnt_en     = 1'b0;
        case (r_state)
            IDLE: begin
                if (apb_psel && apb_penable) begin
                    w_start = 1'b1;
                    if (w_chk_fail) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = ISSUE;
                        w_cnt_load  = 1'b1;
                    end
                end
            end
            ISSUE, WAIT: begin
                if (!apb_psel) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_cnt_en = 1'b1;
                    // An ack in the expiry cycle still completes the transfer cleanly.
                    if (w_ack) begin
                        w_state_nxt  = RESP;
                        w_err_nxt    = w_addrerr;
                        w_prdata_nxt = r_write ? '0 : rdata;
                    end else if (w_expire) begin
                        w_state_nxt = RESP;
                        w_err_nxt   = 1'b1;
                        w_tmo_nxt   = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end
            end
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign apb_pready  = (r_state == RESP);
    assign apb_prdata  = r_prdata;
    assign apb_pslverr = r_pslverr;
    assign bus_tmo     = r_bus_tmo;
    assign rd_en       = (r_state == ISSUE) && !r_write;
    assign wr_en       = (r_state == ISSUE) && r_write;
    assign raddr       = r_addr;
    assign waddr       = r_addr;
    assign wdata       = r_wdata;
    assign wstrb       = r_wstrb;

endmodule
